// File: rtl/syzygy_dac_arbiter_if.sv
// Stream bundle between the two sample sources, the arbiter and the DAC PHY.
// slave  : arbiter side (takes enable/src*_valid/src*_i/src*_q, drives
//          src*_ready, data_i/data_q, grant, underflow_cnt).
// master : source / PHY side, the mirror image.
interface syzygy_dac_arbiter_if #(
    parameter int unsigned DATA_W = 12
);
    logic              enable;
    logic              src0_valid;
    logic              src0_ready;
    logic [DATA_W-1:0] src0_i;
    logic [DATA_W-1:0] src0_q;
    logic              src1_valid;
    logic              src1_ready;
    logic [DATA_W-1:0] src1_i;
    logic [DATA_W-1:0] src1_q;
    logic [DATA_W-1:0] data_i;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        grant;
    logic [15:0]       underflow_cnt;

    modport slave (
        input  enable,
        input  src0_valid, src0_i, src0_q,
        input  src1_valid, src1_i, src1_q,
        output src0_ready, src1_ready,
        output data_i, data_q, grant, underflow_cnt
    );

    modport master (
        output enable,
        output src0_valid, src0_i, src0_q,
        output src1_valid, src1_i, src1_q,
        input  src0_ready, src1_ready,
        input  data_i, data_q, grant, underflow_cnt
    );
endinterface

// File: rtl/syzygy_dac_arbiter.sv
// Round-robin burst arbiter sharing the DAC I/Q path between two sources.
// Ports: clk, reset_n (async, active-low), bus (syzygy_dac_arbiter_if.slave).
// Macro SYZYGY_DAC_ARB_STATS_EN enables the saturating underflow_cnt;
// without it underflow_cnt is tied to 0.
module syzygy_dac_arbiter #(
    parameter int unsigned       DATA_W    = 12,
    parameter int unsigned       BURST_LEN = 256,
    parameter int unsigned       GAP_MAX   = 8,
    parameter logic [DATA_W-1:0] IDLE_CODE = 12'h800
) (
    input logic                 clk,
    input logic                 reset_n,
    syzygy_dac_arbiter_if.slave bus
);
    localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);
    localparam int unsigned GAP_W  = $clog2(GAP_MAX + 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_MAX - 1);

    // Encoding doubles as the one-hot grant output.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] dout_i_q, dout_i_d;
    logic [DATA_W-1:0] dout_q_q, dout_q_d;

    logic              own1;
    logic              rdy0;
    logic              rdy1;
    logic              accept;
    logic              rel;
    logic [DATA_W-1:0] sel_i;
    logic [DATA_W-1:0] sel_q;

    assign own1   = (state_q == GRANT1);
    assign rdy0   = (state_q == GRANT0) & bus.enable;
    assign rdy1   = own1 & bus.enable;
    assign accept = (rdy0 & bus.src0_valid) | (rdy1 & bus.src1_valid);
    assign sel_i  = own1 ? bus.src1_i : bus.src0_i;
    assign sel_q  = own1 ? bus.src1_q : bus.src0_q;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        gap_d    = gap_q;
        last_d   = last_q;
        dout_i_d = IDLE_CODE;
        dout_q_d = IDLE_CODE;
        rel      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable && (bus.src0_valid || bus.src1_valid)) begin
                    // last_q=1 means src1 held the previous grant
                    if (bus.src0_valid && (!bus.src1_valid || last_q))
                        state_d = GRANT0;
                    else
                        state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (!bus.enable) begin
                    rel = 1'b1;
                end else if (accept) begin
                    dout_i_d = sel_i;
                    dout_q_d = sel_q;
                    gap_d    = '0;
                    if (beat_q == BEAT_LAST) rel = 1'b1;
                    else beat_d = beat_q + 1'b1;
                end else begin
                    if (gap_q == GAP_LAST) rel = 1'b1;
                    else gap_d = gap_q + 1'b1;
                end
                if (rel) begin
                    state_d = IDLE;
                    beat_d  = '0;
                    gap_d   = '0;
                    last_d  = own1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            gap_q    <= '0;
            last_q   <= 1'b1;
            dout_i_q <= IDLE_CODE;
            dout_q_q <= IDLE_CODE;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            gap_q    <= gap_d;
            last_q   <= last_d;
            dout_i_q <= dout_i_d;
            dout_q_q <= dout_q_d;
        end
    end

    assign bus.src0_ready = rdy0;
    assign bus.src1_ready = rdy1;
    assign bus.data_i     = dout_i_q;
    assign bus.data_q     = dout_q_q;
    assign bus.grant      = state_q;

`ifdef SYZYGY_DAC_ARB_STATS_EN
    logic [15:0] uf_q, uf_d;
    logic        starve;

    // Enable-low cycles are not starvation.
    assign starve = ((state_q == GRANT0) || (state_q == GRANT1))
                  & bus.enable & ~accept;

    always_comb begin
        uf_d = uf_q;
        if (starve && (uf_q != 16'hFFFF)) uf_d = uf_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) uf_q <= '0;
        else          uf_q <= uf_d;
    end

    assign bus.underflow_cnt = uf_q;
`else
    assign bus.underflow_cnt = 16'd0;
`endif
endmodule
